// File: rtl/control_pkg.sv
// Shared encodings for the control pipe: ISA opcodes, ALU function codes and
// the bit layout of the per-stage control word.
package control_pkg;

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_J     = 5'd1;
    localparam logic [4:0] OP_BNE   = 5'd2;
    localparam logic [4:0] OP_JAL   = 5'd3;
    localparam logic [4:0] OP_JR    = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_BLT   = 5'd6;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_LW    = 5'd8;
    localparam logic [4:0] OP_SETX  = 5'd21;
    localparam logic [4:0] OP_BEX   = 5'd22;

    localparam logic [4:0] ALU_MUL  = 5'd6;
    localparam logic [4:0] ALU_DIV  = 5'd7;

    localparam int unsigned CW_SWITCH_B    = 0;
    localparam int unsigned CW_SEL_PC_T    = 1;
    localparam int unsigned CW_JAL         = 2;
    localparam int unsigned CW_SEL_RSTATUS = 3;
    localparam int unsigned CW_REG_WE      = 4;
    localparam int unsigned CW_MEM_WE      = 5;
    localparam int unsigned CW_MEM_TO_REG  = 6;
    localparam int unsigned CW_IS_MD       = 7;
    localparam int unsigned CW_VALID       = 8;
    localparam int unsigned CW_DST         = 9;
    localparam int unsigned CTRL_W         = 14;

    function automatic logic [4:0] cw_dst(logic [CTRL_W-1:0] w);
        return w[CW_DST +: 5];
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational decode of one instruction into a control word.
// An invalid instruction yields the all-zero bubble word.
module ctrl_decode
    import control_pkg::*;
(
    input  logic [31:0]       instr_i,
    input  logic              valid_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic [4:0] op;
    logic [4:0] alu;
    logic       unused_bits;

    assign op          = instr_i[31:27];
    assign alu         = instr_i[6:2];
    assign unused_bits = ^{instr_i[21:7], instr_i[1:0]};

    always_comb begin
        ctrl_o = '0;
        if (valid_i) begin
            case (op)
                OP_RTYPE: begin
                    ctrl_o[CW_REG_WE] = 1'b1;
                    ctrl_o[CW_IS_MD]  = (alu == ALU_MUL) || (alu == ALU_DIV);
                end
                OP_J:   ctrl_o[CW_SEL_PC_T] = 1'b1;
                OP_BNE: ctrl_o[CW_SWITCH_B] = 1'b1;
                OP_BLT: ctrl_o[CW_SWITCH_B] = 1'b1;
                OP_JR:  ctrl_o[CW_SWITCH_B] = 1'b1;
                OP_JAL: begin
                    ctrl_o[CW_SEL_PC_T] = 1'b1;
                    ctrl_o[CW_JAL]      = 1'b1;
                    ctrl_o[CW_REG_WE]   = 1'b1;
                end
                OP_ADDI: ctrl_o[CW_REG_WE] = 1'b1;
                OP_SW: begin
                    ctrl_o[CW_SWITCH_B] = 1'b1;
                    ctrl_o[CW_MEM_WE]   = 1'b1;
                end
                OP_LW: begin
                    ctrl_o[CW_SWITCH_B]   = 1'b1;
                    ctrl_o[CW_REG_WE]     = 1'b1;
                    ctrl_o[CW_MEM_TO_REG] = 1'b1;
                end
                OP_SETX: ctrl_o[CW_REG_WE]      = 1'b1;
                OP_BEX:  ctrl_o[CW_SEL_RSTATUS] = 1'b1;
                default: ;
            endcase
            ctrl_o[CW_VALID] = 1'b1;
            case (op)
                OP_JAL:  ctrl_o[CW_DST +: 5] = 5'd31;
                OP_SETX: ctrl_o[CW_DST +: 5] = 5'd30;
                default: ctrl_o[CW_DST +: 5] = instr_i[26:22];
            endcase
        end
    end

endmodule

// File: rtl/control_pipe.sv
// Decode-stage control decoder plus NUM_STAGES control pipeline registers,
// with load-use / mul-div bubble insertion, flush and freeze.
module control_pipe
    import control_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned MD_CYCLES  = 17,
    parameter int unsigned CNT_W      = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  instr_d,
    input  logic                         valid_d,
    input  logic                         freeze,
    input  logic                         flush,
    output logic [CTRL_W-1:0]            ctrl_d,
    output logic [CTRL_W-1:0]            ctrl_x,
    output logic [CTRL_W-1:0]            ctrl_w,
    output logic [NUM_STAGES*CTRL_W-1:0] ctrl_all,
    output logic                         stall_d,
    output logic                         md_busy,
    output logic                         md_done
);

    logic [NUM_STAGES-1:0][CTRL_W-1:0] stage_word;
    logic [CTRL_W-1:0]                 stage1_d;
    logic [4:0]                        x_dst;
    logic                              load_use;
    logic                              md_start;
    logic [CNT_W-1:0]                  md_cnt_q, md_cnt_d;
    logic                              md_done_q, md_done_d;

    ctrl_decode u_decode (
        .instr_i (instr_d),
        .valid_i (valid_d & ~flush),
        .ctrl_o  (ctrl_d)
    );

    assign ctrl_x   = stage_word[0];
    assign ctrl_w   = stage_word[NUM_STAGES-1];
    assign ctrl_all = stage_word;

    // Conservative: any of the three register fields counts as a source.
    always_comb begin
        x_dst    = cw_dst(ctrl_x);
        load_use = ctrl_x[CW_VALID] & ctrl_x[CW_MEM_TO_REG] & (x_dst != '0)
                 & ((x_dst == instr_d[26:22]) | (x_dst == instr_d[21:17])
                  | (x_dst == instr_d[16:12]));
        md_busy  = (md_cnt_q != '0);
        stall_d  = valid_d & ~flush
                 & (load_use | md_busy | (ctrl_d[CW_IS_MD] & ctrl_x[CW_IS_MD]));
        stage1_d = (flush | stall_d) ? '0 : ctrl_d;
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [CTRL_W-1:0] word_q, word_d;
        if (k == 0) begin : g_head
            assign word_d = stage1_d;
        end else begin : g_tail
            assign word_d = stage_word[k-1];
        end
        always_ff @(posedge clock) begin
            if (reset) begin
                word_q <= '0;
            end else if (!freeze) begin
                word_q <= word_d;
            end
        end
        assign stage_word[k] = word_q;
    end

    // The counter keeps running under freeze; only the load needs stage 1 to move.
    always_comb begin
        md_start  = ~freeze & ctrl_x[CW_VALID] & ctrl_x[CW_IS_MD];
        md_cnt_d  = md_cnt_q;
        if (md_start) begin
            md_cnt_d = CNT_W'(MD_CYCLES - 1);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
        md_done_d = (md_cnt_q == CNT_W'(1)) & ~md_start;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            md_cnt_q  <= '0;
            md_done_q <= 1'b0;
        end else begin
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
        end
    end

    assign md_done = md_done_q;

endmodule

// File: tb/tb_control_pipe.sv
// Randomised and directed checks of control_pipe for NUM_STAGES 1..4 against
// an edge-by-edge reference model of the stage history and mul/div timing.
module tb_control_pipe;
    import control_pkg::*;

    localparam int unsigned MD = 17;
    localparam logic [4:0] I_R = 5'd0, I_J = 5'd1, I_BNE = 5'd2, I_JAL = 5'd3, I_JR = 5'd4;
    localparam logic [4:0] I_ADDI = 5'd5, I_BLT = 5'd6, I_SW = 5'd7, I_LW = 5'd8;
    localparam logic [4:0] I_SETX = 5'd21, I_BEX = 5'd22, A_MUL = 5'd6, A_DIV = 5'd7;

    logic        clock, reset, valid_d, freeze, flush;
    logic [31:0] instr_d;
    logic [CTRL_W-1:0] cd [1:4];
    logic [CTRL_W-1:0] cx [1:4];
    logic [CTRL_W-1:0] cw [1:4];
    logic stall [1:4];
    logic busy [1:4];
    logic done [1:4];
    logic [1*CTRL_W-1:0] ca1;
    logic [2*CTRL_W-1:0] ca2;
    logic [3*CTRL_W-1:0] ca3;
    logic [4*CTRL_W-1:0] ca4;

    int total = 0;
    int bad = 0;

    control_pipe #(.NUM_STAGES(1), .MD_CYCLES(MD), .CNT_W(5)) u1 (
        .clock(clock), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .freeze(freeze),
        .flush(flush), .ctrl_d(cd[1]), .ctrl_x(cx[1]), .ctrl_w(cw[1]), .ctrl_all(ca1),
        .stall_d(stall[1]), .md_busy(busy[1]), .md_done(done[1]));
    control_pipe #(.NUM_STAGES(2), .MD_CYCLES(MD), .CNT_W(5)) u2 (
        .clock(clock), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .freeze(freeze),
        .flush(flush), .ctrl_d(cd[2]), .ctrl_x(cx[2]), .ctrl_w(cw[2]), .ctrl_all(ca2),
        .stall_d(stall[2]), .md_busy(busy[2]), .md_done(done[2]));
    control_pipe #(.NUM_STAGES(3), .MD_CYCLES(MD), .CNT_W(5)) u3 (
        .clock(clock), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .freeze(freeze),
        .flush(flush), .ctrl_d(cd[3]), .ctrl_x(cx[3]), .ctrl_w(cw[3]), .ctrl_all(ca3),
        .stall_d(stall[3]), .md_busy(busy[3]), .md_done(done[3]));
    control_pipe #(.NUM_STAGES(4), .MD_CYCLES(MD), .CNT_W(5)) u4 (
        .clock(clock), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .freeze(freeze),
        .flush(flush), .ctrl_d(cd[4]), .ctrl_x(cx[4]), .ctrl_w(cw[4]), .ctrl_all(ca4),
        .stall_d(stall[4]), .md_busy(busy[4]), .md_done(done[4]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: hist[s] is what stage s+1 holds; every DUT shares it.
    logic [CTRL_W-1:0] hist [4];
    bit                md_active = 0;
    int                md_last = 0;
    int                cyc = 0;
    logic [CTRL_W-1:0] m_ctrl_d;
    logic              m_stall;

    function automatic logic [31:0] mk(logic [4:0] op, logic [4:0] rd, logic [4:0] rs,
                                       logic [4:0] rt, logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [CTRL_W-1:0] ref_decode(logic [31:0] ins, logic v);
        logic [CTRL_W-1:0] w;
        logic [4:0] op;
        logic [4:0] alu;
        w = '0;
        op = ins[31:27];
        alu = ins[6:2];
        if (v) begin
            w[CW_SWITCH_B]    = op inside {I_BNE, I_BLT, I_SW, I_LW, I_JR};
            w[CW_SEL_PC_T]    = op inside {I_J, I_JAL};
            w[CW_JAL]         = (op == I_JAL);
            w[CW_SEL_RSTATUS] = (op == I_BEX);
            w[CW_REG_WE]      = op inside {I_R, I_ADDI, I_LW, I_JAL, I_SETX};
            w[CW_MEM_WE]      = (op == I_SW);
            w[CW_MEM_TO_REG]  = (op == I_LW);
            w[CW_IS_MD]       = (op == I_R) && (alu inside {A_MUL, A_DIV});
            w[CW_VALID]       = 1'b1;
            w[CW_DST +: 5]    = (op == I_JAL) ? 5'd31 : (op == I_SETX) ? 5'd30 : ins[26:22];
        end
        return w;
    endfunction

    function automatic bit m_busy();
        return md_active && (cyc < md_last);
    endfunction

    function automatic bit m_done();
        return md_active && (cyc == md_last);
    endfunction

    function automatic logic [4*CTRL_W-1:0] exp_all(int n);
        logic [4*CTRL_W-1:0] r;
        r = '0;
        for (int s = 0; s < n; s++) r[s*CTRL_W +: CTRL_W] = hist[s];
        return r;
    endfunction

    function automatic logic [4*CTRL_W-1:0] got_all(int n);
        logic [4*CTRL_W-1:0] r;
        r = '0;
        case (n)
            1: r[1*CTRL_W-1:0] = ca1;
            2: r[2*CTRL_W-1:0] = ca2;
            3: r[3*CTRL_W-1:0] = ca3;
            default: r = ca4;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] ops [12];
        logic [4:0] op;
        ops = '{I_R, I_R, I_J, I_BNE, I_JAL, I_JR, I_ADDI, I_BLT, I_SW, I_LW, I_SETX, I_BEX};
        op = ops[$urandom_range(0, 11)];
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom), 5'($urandom_range(0, 7)), 2'($urandom)};
    endfunction

    task automatic model_comb();
        logic [4:0] xd;
        bit lu;
        m_ctrl_d = ref_decode(instr_d, valid_d && !flush);
        xd = hist[0][CW_DST +: 5];
        lu = hist[0][CW_VALID] && hist[0][CW_MEM_TO_REG] && (xd != 5'd0)
             && (xd == instr_d[26:22] || xd == instr_d[21:17] || xd == instr_d[16:12]);
        m_stall = valid_d && !flush && (lu || m_busy() || (m_ctrl_d[CW_IS_MD] && hist[0][CW_IS_MD]));
    endtask

    task automatic tick();
        model_comb();
        @(posedge clock);
        cyc++;
        if (reset) begin
            for (int s = 0; s < 4; s++) hist[s] = '0;
            md_active = 0;
        end else if (!freeze) begin
            if (hist[0][CW_VALID] && hist[0][CW_IS_MD]) begin
                md_active = 1;
                md_last = cyc + int'(MD) - 1;
            end
            for (int s = 3; s > 0; s--) hist[s] = hist[s-1];
            hist[0] = (flush || m_stall) ? '0 : m_ctrl_d;
        end
        #1;
        model_comb();
    endtask

    task automatic drive(logic [31:0] ins, logic v, logic fl, logic fz);
        instr_d = ins;
        valid_d = v;
        flush = fl;
        freeze = fz;
        #1;
        model_comb();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(mk(I_LW, 5, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        drive(mk(I_LW, 5, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            total++;
            if (cx[n] !== '0) begin bad++; $display("FAIL reset_ctrl_x n=%0d got %h want 0", n, cx[n]); end
            total++;
            if (cw[n] !== '0) begin bad++; $display("FAIL reset_ctrl_w n=%0d got %h want 0", n, cw[n]); end
            total++;
            if ({stall[n], busy[n], done[n]} !== 3'b000)
                begin bad++; $display("FAIL reset_flags n=%0d got %b want 000", n, {stall[n], busy[n], done[n]}); end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] add_i;
        add_i = mk(I_R, 6, 5, 1, 0);
        drive(mk(I_LW, 5, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        tick();
        drive(add_i, 1'b1, 1'b0, 1'b0);
        total++;
        if (stall[3] !== 1'b1) begin bad++; $display("FAIL lu_stall got %b want 1", stall[3]); end
        tick();
        total++;
        if (cx[3] !== '0) begin bad++; $display("FAIL lu_bubble got %h want 0", cx[3]); end
        total++;
        if (stall[3] !== 1'b0) begin bad++; $display("FAIL lu_release got %b want 0", stall[3]); end
        tick();
        total++;
        if (cx[3] !== ref_decode(add_i, 1'b1))
            begin bad++; $display("FAIL lu_issue got %h want %h", cx[3], ref_decode(add_i, 1'b1)); end
    endtask

    task automatic test_mul();
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at = 0;
        drive(mk(I_R, 7, 2, 3, A_MUL), 1'b1, 1'b0, 1'b0);
        tick();
        drive(mk(I_ADDI, 4, 4, 0, 0), 1'b1, 1'b0, 1'b0);
        total++;
        if (stall[3] !== 1'b0) begin bad++; $display("FAIL mul_follow_stall got %b want 0", stall[3]); end
        tick();
        for (int k = 1; k <= 20; k++) begin
            if (busy[3] === 1'b1) busy_cnt++;
            if (done[3] === 1'b1) begin done_cnt++; done_at = k; end
            total++;
            if (stall[3] !== (k <= int'(MD) - 1))
                begin bad++; $display("FAIL mul_stall k=%0d got %b want %b", k, stall[3], k <= int'(MD) - 1); end
            total++;
            if ({busy[3], done[3]} !== {m_busy(), m_done()})
                begin bad++; $display("FAIL mul_model k=%0d got %b want %b", k, {busy[3], done[3]}, {m_busy(), m_done()}); end
            tick();
        end
        total++;
        if (busy_cnt != int'(MD) - 1) begin bad++; $display("FAIL mul_busy_len got %0d want %0d", busy_cnt, MD - 1); end
        total++;
        if (done_cnt != 1 || done_at != int'(MD))
            begin bad++; $display("FAIL mul_done got count %0d at %0d want 1 at %0d", done_cnt, done_at, MD); end
    endtask

    task automatic test_flush();
        logic [31:0] bne_i;
        logic [31:0] jal_i;
        bit jal_seen;
        do_reset();
        bne_i = mk(I_BNE, 3, 4, 0, 0);
        jal_i = {I_JAL, 27'h123_4567};
        drive(bne_i, 1'b1, 1'b0, 1'b0);
        tick();
        drive(jal_i, 1'b1, 1'b1, 1'b0);
        total++;
        if ({cd[3], stall[3]} !== '0) begin bad++; $display("FAIL flush_d got %h/%b want 0/0", cd[3], stall[3]); end
        tick();
        total++;
        if (cx[3] !== '0) begin bad++; $display("FAIL flush_x got %h want 0", cx[3]); end
        total++;
        if (ca3[2*CTRL_W-1 -: CTRL_W] !== ref_decode(bne_i, 1'b1))
            begin bad++; $display("FAIL flush_s2 got %h want %h", ca3[2*CTRL_W-1 -: CTRL_W], ref_decode(bne_i, 1'b1)); end
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        jal_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            for (int s = 0; s < 4; s++) if (ca4[s*CTRL_W + CW_JAL] === 1'b1) jal_seen = 1;
            if (i == 0) begin
                total++;
                if (cw[3] !== ref_decode(bne_i, 1'b1))
                    begin bad++; $display("FAIL flush_w got %h want %h", cw[3], ref_decode(bne_i, 1'b1)); end
            end
        end
        total++;
        if (jal_seen) begin bad++; $display("FAIL flush_jal got seen want absent"); end
    endtask

    task automatic test_freeze();
        logic [4*CTRL_W-1:0] snap;
        do_reset();
        drive(mk(I_R, 9, 1, 2, A_DIV), 1'b1, 1'b0, 1'b0);
        tick();
        drive(mk(I_ADDI, 3, 1, 0, 0), 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 20; k++) begin
            total++;
            if ({busy[3], done[3]} !== {k <= int'(MD) - 1, k == int'(MD)})
                begin bad++; $display("FAIL frz_md k=%0d got %b want %b", k, {busy[3], done[3]}, {k <= int'(MD) - 1, k == int'(MD)}); end
            if (k <= 3) begin
                snap = ca4;
                drive(mk(I_ADDI, 5'($urandom_range(1, 7)), 2, 0, 0), 1'b1, 1'b0, 1'b1);
                tick();
                total++;
                if (ca4 !== snap) begin bad++; $display("FAIL frz_hold k=%0d got %h want %h", k, ca4, snap); end
            end else begin
                drive(32'd0, 1'b0, 1'b0, 1'b0);
                tick();
            end
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        do_reset();
        drive(mk(I_R, 7, 2, 3, A_MUL), 1'b1, 1'b0, 1'b0);
        tick();
        drive(mk(I_ADDI, 4, 4, 0, 0), 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) tick();
        total++;
        if (busy[3] !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got %b want 1", busy[3]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            total++;
            if ({busy[n], done[n], stall[n]} !== 3'b000)
                begin bad++; $display("FAIL rmid_flags n=%0d got %b want 000", n, {busy[n], done[n], stall[n]}); end
            total++;
            if ({cx[n], cw[n], got_all(n)} !== '0) begin bad++; $display("FAIL rmid_words n=%0d got nonzero want 0", n); end
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done[3] !== 1'b0 || busy[3] !== 1'b0) done_seen++;
        end
        total++;
        if (done_seen != 0) begin bad++; $display("FAIL rmid_after got %0d busy/done cycles want 0", done_seen); end
    endtask

    task automatic test_sweep();
        do_reset();
        drive({I_JAL, 27'($urandom)}, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 5; t++) begin
            for (int n = 1; n <= 4; n++) begin
                total++;
                if (cw[n][CW_JAL] !== (t == n))
                    begin bad++; $display("FAIL sweep_jal n=%0d t=%0d got %b want %b", n, t, cw[n][CW_JAL], t == n); end
                if (t == n) begin
                    total++;
                    if (cw[n][CW_DST +: 5] !== 5'd31)
                        begin bad++; $display("FAIL sweep_dst n=%0d got %0d want 31", n, cw[n][CW_DST +: 5]); end
                end
            end
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            drive({I_JAL, 27'($urandom)}, 1'b1, 1'b0, 1'b0);
            tick();
            for (int n = 1; n <= 4; n++) begin
                total++;
                if (cw[n] !== hist[n-1])
                    begin bad++; $display("FAIL stream_w n=%0d got %h want %h", n, cw[n], hist[n-1]); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive(rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0);
            for (int n = 1; n <= 4; n++) begin
                total++;
                if ({cd[n], stall[n]} !== {m_ctrl_d, m_stall})
                    begin bad++; $display("FAIL rnd_comb i=%0d n=%0d got %h/%b want %h/%b", i, n, cd[n], stall[n], m_ctrl_d, m_stall); end
            end
            tick();
            reset = 1'b0;
            for (int n = 1; n <= 4; n++) begin
                total++;
                if ({busy[n], done[n]} !== {m_busy(), m_done()})
                    begin bad++; $display("FAIL rnd_md i=%0d n=%0d got %b want %b", i, n, {busy[n], done[n]}, {m_busy(), m_done()}); end
                total++;
                if (got_all(n) !== exp_all(n) || cx[n] !== hist[0] || cw[n] !== hist[n-1])
                    begin bad++; $display("FAIL rnd_words i=%0d n=%0d got %h want %h", i, n, got_all(n), exp_all(n)); end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) hist[s] = '0;
        reset = 1'b0;
        instr_d = '0;
        valid_d = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        test_reset();
        test_load_use();
        test_mul();
        test_flush();
        test_freeze();
        test_reset_mid();
        test_sweep();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
